// File: rtl/exe_stage.sv
// exe_stage: MIPS execute stage with ALU, BEQ resolve, iterative multiplier and EX/MEM register
module exe_stage #(
  parameter int DSIZE = 32,
  parameter int ISIZE = 32,
  parameter int ASIZE = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [3:0]       aluop_in,
  input  logic             Branch_in,
  input  logic [ISIZE-1:0] PCOUT_in,
  input  logic [DSIZE-1:0] s_ext_in,
  input  logic [DSIZE-1:0] rdata1_in,
  input  logic [DSIZE-1:0] b_in,
  input  logic [DSIZE-1:0] rdata2_in,
  input  logic [ASIZE-1:0] waddr_in,
  input  logic             wen_in,
  input  logic             memread_in,
  input  logic             memwrite_in,
  input  logic             memtoreg_in,
  input  logic             jal_in,
  input  logic             flush_in,
  output logic             stall_out,
  output logic             valid_out,
  output logic [DSIZE-1:0] alu_result_out,
  output logic [DSIZE-1:0] store_data_out,
  output logic [ASIZE-1:0] waddr_out,
  output logic             wen_out,
  output logic             memread_out,
  output logic             memwrite_out,
  output logic             memtoreg_out,
  output logic             branch_taken_out,
  output logic [ISIZE-1:0] branch_target_out
);
  localparam logic [3:0] OP_MUL = 4'd12;
  localparam int CW = $clog2(DSIZE);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [DSIZE-1:0] mul_a, mul_b, prod, alu_res, res;
  logic is_mul, mul_start, mul_last, bubble, taken;
  assign is_mul = valid_in & (aluop_in == OP_MUL);
  assign taken = Branch_in & (rdata1_in == rdata2_in);
  assign bubble = ~valid_in | flush_in | stall_out;
  assign res = jal_in ? DSIZE'(PCOUT_in) : alu_res;
  // multiplier state register; reset and flush both abort a running multiply
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  // multiplier next state: one RUN cycle per operand bit, DONE presents the product
  always_comb
    state_nxt = flush_in ? IDLE :
                state == IDLE ? (is_mul ? RUN : IDLE) :
                state == RUN ? (mul_last ? DONE : RUN) : IDLE;
  // multiplier control outputs; stall is forced low while reset is held
  always_comb begin
    mul_start = (state == IDLE) & is_mul & ~flush_in;
    mul_last = (state == RUN) & (cnt == CW'(DSIZE - 1));
    stall_out = rst & is_mul & (state != DONE) & ~flush_in;
  end
  // shift-add datapath: multiplicand shifts left, multiplier shifts right
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mul_a <= '0;
      mul_b <= '0;
      prod <= '0;
      cnt <= '0;
    end else if (mul_start) begin
      mul_a <= rdata1_in;
      mul_b <= b_in;
      prod <= '0;
      cnt <= '0;
    end else if (state == RUN) begin
      prod <= prod + (mul_b[0] ? mul_a : '0);
      mul_a <= mul_a << 1;
      mul_b <= mul_b >> 1;
      cnt <= cnt + CW'(1);
    end
  // ALU; shifts move B by A[4:0], MUL reads the finished product
  always_comb begin
    alu_res = '0;
    case (aluop_in)
      4'd0:  alu_res = rdata1_in + b_in;
      4'd1:  alu_res = rdata1_in - b_in;
      4'd2:  alu_res = rdata1_in & b_in;
      4'd3:  alu_res = rdata1_in | b_in;
      4'd4:  alu_res = rdata1_in ^ b_in;
      4'd5:  alu_res = ~(rdata1_in | b_in);
      4'd6:  alu_res = DSIZE'($signed(rdata1_in) < $signed(b_in));
      4'd7:  alu_res = DSIZE'(rdata1_in < b_in);
      4'd8:  alu_res = b_in << rdata1_in[4:0];
      4'd9:  alu_res = b_in >> rdata1_in[4:0];
      4'd10: alu_res = DSIZE'($signed(b_in) >>> rdata1_in[4:0]);
      4'd11: alu_res = b_in << 16;
      4'd12: alu_res = prod;
      default: alu_res = '0;
    endcase
  end
  // EX/MEM register; bubbles clear control and keep the data fields
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      valid_out <= 1'b0;
      wen_out <= 1'b0;
      memread_out <= 1'b0;
      memwrite_out <= 1'b0;
      memtoreg_out <= 1'b0;
      branch_taken_out <= 1'b0;
      alu_result_out <= '0;
      store_data_out <= '0;
      waddr_out <= '0;
      branch_target_out <= '0;
    end else begin
      valid_out <= ~bubble;
      wen_out <= ~bubble & wen_in;
      memread_out <= ~bubble & memread_in;
      memwrite_out <= ~bubble & memwrite_in;
      memtoreg_out <= ~bubble & memtoreg_in;
      branch_taken_out <= ~bubble & taken;
      if (!bubble) begin
        alu_result_out <= res;
        store_data_out <= rdata2_in;
        waddr_out <= waddr_in;
        branch_target_out <= PCOUT_in + ISIZE'(s_ext_in << 2);
      end
    end
endmodule
